// File: rtl/cosim_result_serializer.sv
// Buffers 128-bit cosim result vectors in a small FIFO and streams each as four
// 32-bit beats (low word first), with a running beat checksum and vector count.
module cosim_result_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [31:0]      checksum,
  output logic [CNT_W-1:0] vec_count,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0][127:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic [1:0]              idx;
  logic                    full, push, beat, pop;

  // Full comes only from registered occupancy, so a same-cycle pop never frees a slot.
  assign full     = (count == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign beat     = out_valid && out_ready;
  assign pop      = beat && (idx == 2'd3);

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      IDLE: if (push) state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (pop && count == (AW+1)'(1) && !push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_data = out_valid ? mem[rd_ptr][32*idx +: 32] : 32'h0;
  assign out_last = out_valid && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      idx       <= '0;
      checksum  <= '0;
      vec_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (beat) begin
        checksum <= checksum + out_data;
        idx      <= idx + 2'd1;  // wraps 3 -> 0 on the last beat
      end
      if (pop) vec_count <= vec_count + 1'b1;
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is presented until a push has written the slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule
